// File: rtl/display_sel_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : display_sel_ctrl_pkg                                   |
// | Brief   : Shared display-select encodings and helpers used by    |
// |           the selection controller and the display mux.          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package display_sel_ctrl_pkg;

  localparam int DSEL_W = 3;

  typedef logic [DSEL_W-1:0] dsel_t;

  // Display mux selections, in front-panel order
  localparam dsel_t DSEL_STATE  = 3'd0;
  localparam dsel_t DSEL_STATUS = 3'd1;
  localparam dsel_t DSEL_AC     = 3'd2;
  localparam dsel_t DSEL_MB     = 3'd3;
  localparam dsel_t DSEL_MQ     = 3'd4;
  localparam dsel_t DSEL_BUS    = 3'd5;
  localparam dsel_t DSEL_MAX    = DSEL_BUS;

  // Source of a selection change, listed in decreasing priority
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_LOAD = 2'd1,
    EV_STEP = 2'd2,
    EV_SCAN = 2'd3
  } dsel_event_e;

  // Next selection in rotation; anything at or above the last legal
  // code folds back to the first so 6/7 can never be produced.
  function automatic dsel_t dsel_advance(input dsel_t d);
    return (d >= DSEL_MAX) ? DSEL_STATE : d + dsel_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : btn_debounce                                           |
// | Brief   : Synchronizer + four-state debounce FSM for a panel key;|
// |           emits a single-cycle pulse per debounced press.        |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  logic             sync_ff1;
  logic             sync_ff2;
  logic             valid_ff1;
  logic             valid_ff2;
  logic             armed;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Two-flop synchronizer for the raw key, plus a parallel marker that
  // says when the synchronizer holds real samples rather than reset zeros
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      valid_ff1 <= 1'b0;
      valid_ff2 <= 1'b0;
    end else begin
      sync_ff1  <= btn_raw;
      sync_ff2  <= sync_ff1;
      valid_ff1 <= 1'b1;
      valid_ff2 <= valid_ff1;
    end
  end

  // Arm only after a genuine released level is seen, so a key held
  // across reset release cannot produce a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (valid_ff2 && !sync_ff2) begin
      armed <= 1'b1;
    end
  end

  // State register and shared debounce counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic; counter restarts on every state entry
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (sync_ff2 && armed) begin
          state_next = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (!sync_ff2) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        cnt_next = '0;
        if (!sync_ff2) begin
          state_next = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (sync_ff2) begin
          state_next = ST_HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Press pulse fires only on the PRESS_DB -> HELD transition
  always_comb begin
    press = 1'b0;
    if ((state == ST_PRESS_DB) && sync_ff2 && (cnt == CNT_LAST)) begin
      press = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_sel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : display_sel_ctrl                                       |
// | Brief   : Front-panel display selection: debounced DISP step,    |
// |           timed auto-scan and forced MB select on panel load.    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module display_sel_ctrl
  import display_sel_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 50000,
  parameter int SCAN_CYCLES = 12000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_btn,
  input  logic              scan_en,
  input  logic              panel_load,
  output logic [DSEL_W-1:0] dsel,
  output logic              step_ack
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              step_req;
  logic              scan_tick;
  dsel_event_e       ev_sel;
  dsel_t             dsel_next;
  logic              ack_next;
  logic [SCAN_W-1:0] scan_cnt;
  logic [SCAN_W-1:0] scan_cnt_next;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .press   (step_req)
  );

  // Dwell expiry while scanning
  always_comb begin
    scan_tick = scan_en && (scan_cnt == SCAN_LAST);
  end

  // Pick the single winning event; losers in the same cycle are dropped
  always_comb begin
    ev_sel = EV_NONE;
    if (panel_load) begin
      ev_sel = EV_LOAD;
    end else if (step_req) begin
      ev_sel = EV_STEP;
    end else if (scan_tick) begin
      ev_sel = EV_SCAN;
    end
  end

  // Apply the winning event; any event restarts the dwell
  always_comb begin
    dsel_next     = dsel;
    ack_next      = 1'b0;
    scan_cnt_next = scan_en ? (scan_cnt + SCAN_W'(1)) : '0;
    case (ev_sel)
      EV_LOAD: begin
        dsel_next     = DSEL_MB;
        ack_next      = (dsel != DSEL_MB);
        scan_cnt_next = '0;
      end
      EV_STEP, EV_SCAN: begin
        dsel_next     = dsel_advance(dsel);
        ack_next      = 1'b1;
        scan_cnt_next = '0;
      end
      default: begin
      end
    endcase
  end

  // Selection, acknowledge and dwell counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dsel     <= DSEL_STATE;
      step_ack <= 1'b0;
      scan_cnt <= '0;
    end else begin
      dsel     <= dsel_next;
      step_ack <= ack_next;
      scan_cnt <= scan_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_sel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_display_sel_ctrl                                    |
// | Brief   : Self-checking bench for display_sel_ctrl: directed     |
// |           sequences, a vector table and random traffic against   |
// |           a run-length reference model.                          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_display_sel_ctrl;

  localparam int DB   = 4;
  localparam int SCAN = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       step_btn = 1'b0;
  logic       scan_en = 1'b0;
  logic       panel_load = 1'b0;
  logic [2:0] dsel;
  logic       step_ack;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  // Reference model state (abstract: delayed samples + run length)
  int m_s1, m_s2, m_run, m_dl, m_armed, m_edges, m_dsel, m_scan, m_ack;

  typedef struct {
    logic pl;
    logic se;
    int   n;
    int   exp_dsel;
    int   exp_ack;
  } vec_t;

  vec_t tbl[13];

  display_sel_ctrl #(
    .DB_CYCLES   (DB),
    .SCAN_CYCLES (SCAN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_btn   (step_btn),
    .scan_en    (scan_en),
    .panel_load (panel_load),
    .dsel       (dsel),
    .step_ack   (step_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (step_ack) ack_cnt++;
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_dl = 0; m_armed = 0;
    m_edges = 0; m_dsel = 0; m_scan = 0; m_ack = 0;
  endtask

  task automatic do_reset();
    step_btn = 1'b0;
    scan_en = 1'b0;
    panel_load = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic press(input int hold, input int rel);
    step_btn = 1'b1;
    run_cycles(hold);
    step_btn = 1'b0;
    run_cycles(rel);
  endtask

  // One clock edge of the behavioural model, given the inputs at that edge.
  // A level counts once the synchronized key differs from the debounced
  // level for DB+1 consecutive samples; a rising change is a step.
  task automatic model_step(input logic btn, input logic se, input logic pl);
    logic pr;
    logic tk;
    pr = 1'b0;
    if ((m_s2 != m_dl) && (m_dl != 0 || m_armed != 0)) begin
      m_run++;
      if (m_run == DB + 1) begin
        pr = (m_dl == 0);
        m_dl = (m_dl == 0) ? 1 : 0;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    tk = se && (m_scan == SCAN - 1);
    m_ack = 0;
    if (pl) begin
      m_ack = (m_dsel != 3) ? 1 : 0;
      m_dsel = 3;
      m_scan = 0;
    end else if (pr || tk) begin
      m_dsel = (m_dsel + 1) % 6;
      m_ack = 1;
      m_scan = 0;
    end else begin
      m_scan = se ? m_scan + 1 : 0;
    end
    if (m_edges >= 2 && m_s2 == 0) m_armed = 1;
    if (m_edges < 2) m_edges++;
    m_s2 = m_s1;
    m_s1 = btn ? 1 : 0;
  endtask

  initial begin
    int change_at;
    int hold_left;

    tbl[0]  = '{pl: 1'b1, se: 1'b0, n: 1,  exp_dsel: 3, exp_ack: 1};
    tbl[1]  = '{pl: 1'b0, se: 1'b0, n: 1,  exp_dsel: 3, exp_ack: 0};
    tbl[2]  = '{pl: 1'b1, se: 1'b0, n: 1,  exp_dsel: 3, exp_ack: 0};
    tbl[3]  = '{pl: 1'b0, se: 1'b1, n: 9,  exp_dsel: 3, exp_ack: 0};
    tbl[4]  = '{pl: 1'b0, se: 1'b1, n: 1,  exp_dsel: 4, exp_ack: 1};
    tbl[5]  = '{pl: 1'b0, se: 1'b1, n: 5,  exp_dsel: 4, exp_ack: 0};
    tbl[6]  = '{pl: 1'b1, se: 1'b1, n: 1,  exp_dsel: 3, exp_ack: 1};
    tbl[7]  = '{pl: 1'b0, se: 1'b1, n: 9,  exp_dsel: 3, exp_ack: 0};
    tbl[8]  = '{pl: 1'b0, se: 1'b0, n: 1,  exp_dsel: 3, exp_ack: 0};
    tbl[9]  = '{pl: 1'b0, se: 1'b1, n: 9,  exp_dsel: 3, exp_ack: 0};
    tbl[10] = '{pl: 1'b0, se: 1'b1, n: 1,  exp_dsel: 4, exp_ack: 1};
    tbl[11] = '{pl: 1'b0, se: 1'b1, n: 10, exp_dsel: 5, exp_ack: 1};
    tbl[12] = '{pl: 1'b0, se: 1'b1, n: 10, exp_dsel: 0, exp_ack: 1};

    // Reset state
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dsel", dsel, 0);
    check("reset_ack", step_ack, 0);
    reset = 1'b1;
    run_cycles(5);

    // Clean press: latency 2 sync + 4 debounce + 1, no repeat while held
    ack_cnt = 0;
    change_at = -1;
    step_btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      run_cycles(1);
      if (change_at < 0 && dsel != 3'd0) change_at = e;
    end
    check("clean_latency", change_at, 7);
    check("clean_dsel", dsel, 1);
    check("clean_acks", ack_cnt, 1);
    step_btn = 1'b0;
    run_cycles(12);
    check("clean_release_dsel", dsel, 1);
    check("clean_release_acks", ack_cnt, 1);

    // Press bounce then stable high: one step; release bounce: none
    ack_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step_btn = 1'b1; run_cycles(2);
      step_btn = 1'b0; run_cycles(2);
    end
    step_btn = 1'b1;
    run_cycles(20);
    check("bounce_press_acks", ack_cnt, 1);
    check("bounce_press_dsel", dsel, 2);
    ack_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step_btn = 1'b0; run_cycles(2);
      step_btn = 1'b1; run_cycles(2);
    end
    step_btn = 1'b0;
    run_cycles(20);
    check("bounce_release_acks", ack_cnt, 0);
    check("bounce_release_dsel", dsel, 2);

    // Six presses walk the full rotation with wrap
    do_reset();
    run_cycles(5);
    for (int i = 0; i < 6; i++) begin
      press(10, 12);
      check("rotate_dsel", dsel, (i + 1) % 6);
    end

    // Vector table: panel load / scan priority and dwell
    do_reset();
    run_cycles(5);
    for (int r = 0; r < 13; r++) begin
      panel_load = tbl[r].pl;
      scan_en = tbl[r].se;
      run_cycles(tbl[r].n);
      check("table_dsel", dsel, tbl[r].exp_dsel);
      check("table_ack", step_ack, tbl[r].exp_ack);
    end
    panel_load = 1'b0;
    scan_en = 1'b0;

    // Auto-scan from 4, then manual step restarts the dwell
    do_reset();
    run_cycles(5);
    panel_load = 1'b1;
    run_cycles(1);
    panel_load = 1'b0;
    press(10, 12);
    check("scan_start_dsel", dsel, 4);
    scan_en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      run_cycles(1);
      if (e == 9)  check("scan_e9_dsel", dsel, 4);
      if (e == 10) check("scan_e10_dsel", dsel, 5);
      if (e == 10) check("scan_e10_ack", step_ack, 1);
      if (e == 20) check("scan_e20_dsel", dsel, 0);
    end
    step_btn = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      run_cycles(1);
      if (e == 6)  check("manual_e6_dsel", dsel, 0);
      if (e == 7)  check("manual_e7_dsel", dsel, 1);
      if (e == 7)  check("manual_e7_ack", step_ack, 1);
      if (e == 16) check("manual_e16_dsel", dsel, 1);
      if (e == 17) check("manual_e17_dsel", dsel, 2);
    end
    step_btn = 1'b0;
    scan_en = 1'b0;
    run_cycles(12);

    // Panel load coincident with scan tick
    do_reset();
    run_cycles(5);
    press(10, 12);
    check("load_tick_pre_dsel", dsel, 1);
    scan_en = 1'b1;
    run_cycles(9);
    ack_cnt = 0;
    panel_load = 1'b1;
    run_cycles(1);
    check("load_tick_dsel", dsel, 3);
    panel_load = 1'b0;
    run_cycles(1);
    check("load_tick_after_dsel", dsel, 3);
    check("load_tick_acks", ack_cnt, 1);
    scan_en = 1'b0;

    // Reset during PRESS_DB; key held across release must not step
    do_reset();
    run_cycles(5);
    press(10, 12);
    press(10, 12);
    check("rst_pre_dsel", dsel, 2);
    step_btn = 1'b1;
    run_cycles(4);
    reset = 1'b0;
    #1;
    check("rst_async_dsel", dsel, 0);
    check("rst_async_ack", step_ack, 0);
    run_cycles(2);
    reset = 1'b1;
    ack_cnt = 0;
    run_cycles(30);
    check("rst_held_acks", ack_cnt, 0);
    check("rst_held_dsel", dsel, 0);
    step_btn = 1'b0;
    run_cycles(12);
    press(10, 12);
    check("rst_repress_dsel", dsel, 1);

    // Random traffic against the reference model
    do_reset();
    hold_left = 8;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        step_btn = ~step_btn;
        hold_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(6, 16));
      end else begin
        hold_left--;
      end
      if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
      panel_load = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      model_step(step_btn, scan_en, panel_load);
      #1;
      check("rand_dsel", dsel, m_dsel);
      check("rand_ack", step_ack, m_ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_sel_ctrl.md
DISPLAY_SEL_CTRL -- requirements
Module: display_sel_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000: cycles an input level must hold stable to count as debounced.
REQ-002 SHALL have parameter SCAN_CYCLES, default 12000000: auto-scan dwell per display selection.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port step_btn, input, 1: raw, asynchronous, bouncing front-panel DISP step button; high means pressed.
REQ-006 SHALL have port scan_en, input, 1: level; 1 enables auto-scan through the selections.
REQ-007 SHALL have port panel_load, input, 1: single-cycle pulse on completion of an examine or deposit from the switch logic.
REQ-008 SHALL have port dsel, output, 3: the selection driven to the display mux; legal values 0..5 (state, status, ac, mb, mq, io_bus).
REQ-009 SHALL have port step_ack, output, 1: single-cycle pulse on every dsel change.

Function
REQ-010 SHALL pass step_btn through a two-flop synchronizer before any use.
REQ-011 SHALL run a button FSM with states IDLE, PRESS_DB, HELD, RELEASE_DB, sharing one debounce counter.
- IDLE: synced button = 1 -> PRESS_DB, counter cleared.
- PRESS_DB: button = 0 -> IDLE; counter reaches DB_CYCLES-1 -> HELD, issuing one step request.
- HELD: button = 0 -> RELEASE_DB, counter cleared.
- RELEASE_DB: button = 1 -> HELD; counter reaches DB_CYCLES-1 -> IDLE.
REQ-012 SHALL produce exactly one step per debounced press; holding the button SHALL never auto-repeat.
REQ-013 SHALL advance dsel by 1 per step, wrapping 5 -> 0; values 6 and 7 SHALL never be output.
REQ-014 While scan_en = 1, SHALL advance dsel (same wrap rule) each time the scan counter reaches SCAN_CYCLES-1, then clear the counter.
REQ-015 While scan_en = 0, SHALL hold the scan counter at 0.
REQ-016 A manual step SHALL clear the scan counter, giving a full dwell after the manual change.
REQ-017 panel_load SHALL force dsel to 3 (mb) on the next edge and clear the scan counter.
REQ-018 Simultaneous-event priority: panel_load > manual step > scan tick; a lower-priority event in the same cycle SHALL be discarded, not queued.
REQ-019 dsel SHALL update 1 cycle after the deciding event; step_ack SHALL assert in that same cycle.
REQ-020 step_ack SHALL not assert if panel_load occurs while dsel is already 3.
REQ-021 Counters SHALL be sized to clog2 of their parameter and SHALL never wrap silently.

Reset
REQ-022 reset low SHALL immediately force: FSM = IDLE, both counters = 0, synchronizer flops = 0, dsel = 0, step_ack = 0.
REQ-023 Reset asserted mid-debounce or mid-dwell SHALL discard the partial count; no step SHALL be produced by a press spanning reset release until the button is seen low and then re-debounced.

Structure
REQ-024 The dsel encodings (DSEL_STATE=0 ... DSEL_BUS=5, DSEL_MAX=5) SHALL live in the shared parameters include, so the display mux and this block share one definition.
REQ-025 FSM state encodings SHALL be local to this module.
REQ-026 The debounce logic (synchronizer, FSM, counter) SHALL be one sub-module, btn_debounce, emitting a one-cycle press pulse; it is reusable for other panel keys.

Verification (DB_CYCLES=4, SCAN_CYCLES=10)
REQ-027 Clean press held 20 cycles from dsel = 0 -> dsel = 1 with one step_ack, within 2 (sync) + 4 (debounce) + 1 cycles of the press; no further change while held.
REQ-028 Bounce 1,0,1,0 at 2-cycle intervals, then stable high -> exactly one step; release bounce -> no step.
REQ-029 Six debounced presses from 0 -> dsel sequence 1, 2, 3, 4, 5, 0.
REQ-030 scan_en = 1 from dsel = 4 -> 5 after 10 cycles, 0 after 20; a manual step at cycle 7 -> dsel changes at once and the next scan tick lands 10 cycles later.
REQ-031 panel_load in the same cycle as a scan tick, dsel = 1 -> dsel = 3 and a single step_ack.
REQ-032 reset pulsed low during PRESS_DB with dsel = 2 -> dsel = 0 immediately, and no step after release while the button stays high.
